// File: rtl/iter_cmp_pkg.sv
// Shared types and helpers for the iterative magnitude/equality comparator.
package iter_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width needed to count 0..n scan cycles
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module chunk_cmp #(
    parameter int unsigned CHUNK = 2
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    output logic             ch_eq,
    output logic             ch_lt
);

    assign ch_eq = &(x ~^ y);
    assign ch_lt = (x < y);

endmodule

// File: rtl/iter_compare.sv
// Multi-cycle signed/unsigned comparator scanning CHUNK bits per cycle, MSB first.
// ITER_CMP_EARLY_EXIT_EN: stop scanning at the first differing chunk.
module iter_compare
    import iter_cmp_pkg::*;
#(
    parameter  int unsigned WIDTH  = 8,
    parameter  int unsigned CHUNK  = 2,
    localparam int unsigned NCHUNK = WIDTH / CHUNK,
    localparam int unsigned CW     = cnt_width(NCHUNK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic             less,
    output logic             greater,
    output logic [CW-1:0]    cycles
);

    localparam int unsigned IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t           state, state_n;
    logic [WIDTH-1:0] a_q, a_n, b_q, b_n;
    logic             sgn_q, sgn_n;
    logic [IW-1:0]    idx_q, idx_n;
    logic             dec_q, dec_n;
    logic [CW-1:0]    cyc_n;
    logic             eq_n, lt_n, gt_n;
    logic [CHUNK-1:0] ca_c, cb_c;
    logic             ch_eq, ch_lt;
    logic             exit_c;

    // Select the current chunk; the top chunk gets its sign bit flipped in signed mode
    always_comb begin
        ca_c = a_q[int'(idx_q)*CHUNK +: CHUNK];
        cb_c = b_q[int'(idx_q)*CHUNK +: CHUNK];
        if (sgn_q && (idx_q == IW'(NCHUNK - 1))) begin
            ca_c[CHUNK-1] = ~ca_c[CHUNK-1];
            cb_c[CHUNK-1] = ~cb_c[CHUNK-1];
        end
    end

    chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
        .x     (ca_c),
        .y     (cb_c),
        .ch_eq (ch_eq),
        .ch_lt (ch_lt)
    );

    // Next-state and datapath update
    always_comb begin
        state_n = state;
        a_n     = a_q;
        b_n     = b_q;
        sgn_n   = sgn_q;
        idx_n   = idx_q;
        dec_n   = dec_q;
        cyc_n   = cycles;
        eq_n    = equal;
        lt_n    = less;
        gt_n    = greater;
        exit_c  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    a_n     = a;
                    b_n     = b;
                    sgn_n   = is_signed;
                    idx_n   = IW'(NCHUNK - 1);
                    dec_n   = 1'b0;
                    cyc_n   = '0;
                    eq_n    = 1'b0;
                    lt_n    = 1'b0;
                    gt_n    = 1'b0;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                cyc_n = cycles + CW'(1);
                // Only the first differing chunk decides the ordering
                if (!dec_q && !ch_eq) begin
                    lt_n  = ch_lt;
                    gt_n  = ~ch_lt;
                    dec_n = 1'b1;
                end
                if ((idx_q == '0) && !dec_q && ch_eq) begin
                    eq_n = 1'b1;
                end
`ifdef ITER_CMP_EARLY_EXIT_EN
                exit_c = !ch_eq || (idx_q == '0);
`else
                exit_c = (idx_q == '0);
`endif
                if (exit_c) begin
                    state_n = DONE;
                end else begin
                    idx_n = idx_q - IW'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register with registered busy/done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n != IDLE);
            done  <= (state_n == DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            idx_q   <= '0;
            dec_q   <= 1'b0;
            cycles  <= '0;
            equal   <= 1'b0;
            less    <= 1'b0;
            greater <= 1'b0;
        end else begin
            a_q     <= a_n;
            b_q     <= b_n;
            sgn_q   <= sgn_n;
            idx_q   <= idx_n;
            dec_q   <= dec_n;
            cycles  <= cyc_n;
            equal   <= eq_n;
            less    <= lt_n;
            greater <= gt_n;
        end
    end

endmodule
